// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer: FSM state encoding and prescaler divide helper.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  // Zero tick rate yields DIV=0, which the divider rejects at elaboration.
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned tick_hz);
    return (tick_hz == 0) ? 0 : clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// System-clock prescaler: strobes combinationally on the last cycle of each unit while enabled.
module tick_divider #(
  parameter int unsigned CLK_HZ  = 50000000,
  parameter int unsigned TICK_HZ = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic strobe
);
  import timer_pkg::*;

  localparam int unsigned DIV = calc_div(CLK_HZ, TICK_HZ);
  localparam int unsigned PW  = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  if (DIV < 2) begin : g_bad_div
    $error("tick_divider: CLK_HZ/TICK_HZ must be at least 2");
  end

  logic [PW-1:0] r_cnt;

  // Holding (rather than clearing) while disabled lets a pause resume mid-unit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + PW'(1);
    end
  end

  assign strobe = en && (r_cnt == LAST);

endmodule

// File: rtl/countdown_timer.sv
// Game-round countdown timer: load/pause/auto-reload FSM around a per-unit prescaler.
module countdown_timer #(
  parameter int unsigned WIDTH   = 5,
  parameter int unsigned CLK_HZ  = 50000000,
  parameter int unsigned TICK_HZ = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             pause,
  input  logic             reload_en,
  output logic [WIDTH-1:0] timeleft,
  output logic             running,
  output logic             end_f,
  output logic             end_pulse,
  output logic             tick
);
  import timer_pkg::*;

  logic [1:0]       r_rst_sync;
  logic             w_rst_n;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_timeleft;
  logic [WIDTH-1:0] r_reload;
  logic [WIDTH-1:0] w_timeleft_nxt;
  logic [WIDTH-1:0] w_reload_nxt;
  logic             r_running;
  logic             r_end_f;
  logic             r_end_pulse;
  logic             r_tick;
  logic             w_running_nxt;
  logic             w_end_f_nxt;
  logic             w_end_pulse_nxt;
  logic             w_tick_nxt;
  logic             w_div_en;
  logic             w_div_strobe;
  logic             w_expire;

  // Reset asserts immediately but releases on a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_sync <= '0;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[1];

  // PAUSED with pause low counts on the release edge, same as RUN.
  assign w_div_en = !load && !pause &&
                    ((r_state == ST_RUN) || (r_state == ST_PAUSED));

  tick_divider #(
    .CLK_HZ (CLK_HZ),
    .TICK_HZ(TICK_HZ)
  ) u_div (
    .clk   (clk),
    .rst_n (w_rst_n),
    .clr   (load),
    .en    (w_div_en),
    .strobe(w_div_strobe)
  );

  assign w_expire = w_div_strobe && (r_timeleft == WIDTH'(1));

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state     <= ST_IDLE;
      r_timeleft  <= '0;
      r_reload    <= '0;
      r_running   <= 1'b0;
      r_end_f     <= 1'b0;
      r_end_pulse <= 1'b0;
      r_tick      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_timeleft  <= w_timeleft_nxt;
      r_reload    <= w_reload_nxt;
      r_running   <= w_running_nxt;
      r_end_f     <= w_end_f_nxt;
      r_end_pulse <= w_end_pulse_nxt;
      r_tick      <= w_tick_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_timeleft_nxt = r_timeleft;
    w_reload_nxt   = r_reload;
    if (load) begin
      w_timeleft_nxt = load_val;
      w_reload_nxt   = load_val;
      w_state_nxt    = (load_val == '0) ? ST_EXPIRED : ST_RUN;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_IDLE;
        end
        ST_RUN, ST_PAUSED: begin
          if (pause) begin
            w_state_nxt = ST_PAUSED;
          end else begin
            w_state_nxt = ST_RUN;
            if (w_expire) begin
              if (reload_en && (r_reload != '0)) begin
                w_timeleft_nxt = r_reload;
              end else begin
                w_timeleft_nxt = '0;
                w_state_nxt    = ST_EXPIRED;
              end
            end else if (w_div_strobe) begin
              w_timeleft_nxt = r_timeleft - WIDTH'(1);
            end
          end
        end
        ST_EXPIRED: begin
          w_state_nxt = ST_EXPIRED;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    w_running_nxt   = (w_state_nxt == ST_RUN);
    w_end_f_nxt     = (w_state_nxt == ST_EXPIRED);
    w_tick_nxt      = w_div_strobe;
    w_end_pulse_nxt = load ? (load_val == '0) : w_expire;
  end

  assign timeleft  = r_timeleft;
  assign running   = r_running;
  assign end_f     = r_end_f;
  assign end_pulse = r_end_pulse;
  assign tick      = r_tick;

endmodule
